ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 command transmitter: the send side of the PS/2 link, complementing the existing receive path.
- Takes one command byte, for example 0xF4 (enable data reporting) or 0xFF (reset), and runs the full inhibit / request-to-send / clocked-bit / ACK sequence.
- Sits between the top-level open-drain PS2_CLK/PS2_DAT buffers and the mouse-init/command logic, and shares those lines with the receiver.

Parameters:
- INHIBIT_CYCLES, 5000: cycles the host holds clock low before the request (100 us at 50 MHz).
- START_TIMEOUT, 750000: max cycles from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT, 100000: max cycles from the first device falling edge to ACK (2 ms).
- SYNC_STAGES, 2: synchronizer depth on ps2_clk_in/ps2_dat_in.

Ports:
- CLOCK_50, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- the_command, input, 8: byte to send; sampled when a command is accepted.
- send_command, input, 1: request strobe; accepted only in IDLE.
- ps2_clk_in, input, 1: raw PS2_CLK line level.
- ps2_dat_in, input, 1: raw PS2_DAT line level.
- ps2_clk_drive_low, output, 1: 1 means the top level pulls PS2_CLK to 0; 0 means hi-Z.
- ps2_dat_drive_low, output, 1: 1 means the top level pulls PS2_DAT to 0; 0 means hi-Z.
- busy, output, 1: high from the accept cycle until the cycle after done or error.
- command_was_sent, output, 1: single-cycle pulse on a successful ACK.
- error_communication_timed_out, output, 1: single-cycle pulse on timeout or NACK.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-transfer releases both lines on the next edge and emits no pulse.
- Inputs pass through a SYNC_STAGES flop chain. The falling edge of the clock is detected as sync prev=1, cur=0; edge detection adds 1 cycle of latency beyond the sync chain.
- IDLE:
  - on send_command=1, latch the byte, compute odd parity as ~^byte, set busy=1 and go to INHIBIT.
  - send_command while busy is ignored, not queued.
- INHIBIT:
  - clk_drive_low=1 for INHIBIT_CYCLES cycles.
  - In the final cycle also set dat_drive_low=1 (start bit), then go to REQ.
- REQ:
  - release clock (clk_drive_low=0) and keep dat_drive_low=1.
  - Wait for falling edge 1; if none within START_TIMEOUT, go to ERR.
- SEND:
  - shift register {stop=1, parity, d7..d0}, LSB first.
  - On falling edges 1..8 drive d0..d7; on edge 9 drive parity; on edge 10 release data (stop bit).
  - Drive rule: dat_drive_low = ~bit, updated the cycle after the edge is detected.
- ACK:
  - on falling edge 11, sample synced data.
  - 0 means ACK; go to RELEASE.
  - 1 means NACK; go to ERR.
- RELEASE: wait for synced clk=1 and dat=1, then pulse command_was_sent and go to IDLE.
- XFER_TIMEOUT runs from edge 1 through RELEASE; expiry goes to ERR.
- ERR: release both lines, pulse error_communication_timed_out for 1 cycle, go to IDLE.
- Lines are never driven outside INHIBIT/REQ/SEND, and clk_drive_low is 0 outside INHIBIT.
- Counters are wide enough for the max parameter value (20 bits at the defaults) and saturate; they do not wrap.
- busy clears the cycle after the pulse, so back-to-back commands need 1 IDLE cycle.

Optional Feature:
- PS2_TX_RETRY_EN defined: on NACK or any timeout, restart once from INHIBIT with the same latched byte. busy stays high through the retry. The error pulse is emitted only if the retry also fails; success on retry gives a normal command_was_sent.
- Not defined: the first failure goes straight to ERR.

Test Plan:
- Model device with a 12 kHz clock; send 0xF4.
  - Data bits observed on the line: 0,0,1,0,1,1,1,1, then parity 0 and stop released.
  - Device ACKs with 0 on edge 11; command_was_sent pulses once; clk held low 5000 cycles first.
- Send 0xFF, then 0x00 with 1 idle cycle between: parity bits observed are 1 and 1; two success pulses; no error.
- Device never clocks after REQ: error_communication_timed_out pulses at 750000 cycles after clock release (plus sync latency); both drive_low outputs are 0.
- Device NACKs 0xF4 (data high on edge 11):
  - without the macro, 1 error pulse and no sent pulse;
  - with PS2_TX_RETRY_EN and an ACK on the retry, a second INHIBIT phase is seen, then 1 sent pulse and no error.
- Assert reset after edge 5 of a 0xAA transfer: next cycle both drive_low are 0 and busy is 0, no pulses; a subsequent 0x55 completes normally.
- send_command pulsed during SEND with 0x12: ignored; the original byte completes, and exactly one success pulse follows.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, clocked bits, ACK).
// Define PS2_TX_RETRY_EN to restart a failed command once before reporting an error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);
    localparam int MAX_AB = INHIBIT_CYCLES > START_TIMEOUT ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int MAX_P  = MAX_AB > XFER_TIMEOUT ? MAX_AB : XFER_TIMEOUT;
    localparam int CW     = $clog2(MAX_P + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] XT_LAST  = CW'(XFER_TIMEOUT - 1);
`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, RELEASE, ERR} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [3:0]             edge_q, edge_d;
    logic [7:0]             byte_q, byte_d;
    logic [9:0]             shift_q, shift_d;
    logic                   bit_low_q, bit_low_d;
    logic                   retry_q, retry_d;
    logic                   clk_s, dat_s, fall, in_xfer, fail;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign dat_s   = dat_sync_q[SYNC_STAGES-1];
    assign fall    = clk_prev_q & ~clk_s;
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CW'(1);
    assign in_xfer = state_q == SEND || state_q == ACK || state_q == RELEASE;

    assign ps2_clk_drive_low             = state_q == INHIBIT;
    assign ps2_dat_drive_low             = (state_q == INHIBIT && cnt_q >= INH_LAST) || state_q == REQ ||
                                           (state_q == SEND && bit_low_q);
    assign busy                          = state_q != IDLE;
    assign command_was_sent              = state_q == RELEASE && clk_s && dat_s;
    assign error_communication_timed_out = state_q == ERR;

    // Idle lines float high, so the synchronizers reset to 1 to avoid a phantom falling edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            bit_low_q  <= 1'b0;
            retry_q    <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_in};
            clk_prev_q <= clk_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            bit_low_q  <= bit_low_d;
            retry_q    <= retry_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        edge_d    = edge_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        bit_low_d = bit_low_q;
        retry_d   = retry_q;
        fail      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (send_command) begin
                    byte_d  = the_command;
                    retry_d = 1'b0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: if (cnt_q >= INH_LAST) begin
                cnt_d   = '0;
                shift_d = {1'b1, ~^byte_q, byte_q};
                state_d = REQ;
            end
            REQ: if (fall) begin
                cnt_d     = '0;
                edge_d    = 4'd1;
                bit_low_d = ~shift_q[0];
                shift_d   = {1'b1, shift_q[9:1]};
                state_d   = SEND;
            end else if (cnt_q >= ST_LAST) begin
                fail = 1'b1;
            end
            SEND: if (fall) begin
                edge_d    = edge_q + 4'd1;
                bit_low_d = ~shift_q[0];
                shift_d   = {1'b1, shift_q[9:1]};
                state_d   = edge_q == 4'd9 ? ACK : SEND;
            end
            ACK: if (fall) begin
                edge_d  = edge_q + 4'd1;
                state_d = RELEASE;
                fail    = dat_s;
            end
            RELEASE: if (clk_s && dat_s) state_d = IDLE;
            ERR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (in_xfer && cnt_q >= XT_LAST && !command_was_sent) fail = 1'b1;
        if (fail) begin
            cnt_d   = '0;
            retry_d = 1'b1;
            state_d = (RETRY && !retry_q) ? INHIBIT : ERR;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: random and directed commands against a PS/2 device model;
// expected frames come from byte value and bit population, not from the host's internals.
module tb_ps2_host_tx;
    localparam int INH = 40;
    localparam int ST  = 3000;
    localparam int XT  = 4000;

    logic       clk = 1'b0, rst = 1'b1, send = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       dev_clk = 1'b1, dev_dat = 1'b1;
    logic       clk_dl, dat_dl, busy, sent, err;
    logic       clk_line, dat_line;
    int         n_cmp = 0, n_bad = 0, n_sent = 0, n_err = 0;

    assign clk_line = dev_clk & ~clk_dl;
    assign dat_line = dev_dat & ~dat_dl;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT), .SYNC_STAGES(2)) dut (
        .CLOCK_50(clk), .reset(rst), .the_command(cmd), .send_command(send),
        .ps2_clk_in(clk_line), .ps2_dat_in(dat_line),
        .ps2_clk_drive_low(clk_dl), .ps2_dat_drive_low(dat_dl), .busy(busy),
        .command_was_sent(sent), .error_communication_timed_out(err)
    );

    always @(negedge clk) begin
        if (sent) n_sent++;
        if (err) n_err++;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [9:0] frame(input logic [7:0] b);
        logic p;
        p = ($countones(b) % 2) == 0;
        return {1'b1, p, b};
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        cmd  = b;
        send = 1'b1;
        tick(1);
        send = 1'b0;
    endtask

    // Device side: observe inhibit + request, then clock 11 bits; abort_at stops after that falling edge.
    task automatic device(input bit nack, input int half, input int abort_at, input int inject_at,
                          output logic [9:0] bits);
        int   t;
        logic dlow;
        bits = '1;
        t    = 0;
        dlow = 1'b0;
        while (!clk_dl && t < 50) begin tick(1); t++; end
        t = 0;
        while (clk_dl && t < 4 * INH) begin dlow = dat_dl; tick(1); t++; end
        check("inhibit_len", t, INH);
        check("start_bit", dlow, 1);
        check("req_lines", {clk_dl, dat_dl}, 2'b01);
        tick(20 + $urandom_range(0, 80));
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == inject_at) begin
                cmd  = 8'h12;
                send = 1'b1;
                tick(1);
                send = 1'b0;
                tick(half - 1);
            end else begin
                tick(half);
            end
            if (k == abort_at) return;
            if (k <= 10) bits[k-1] = dat_line;
            dev_clk = 1'b1;
            tick(half);
            if (k == 10) begin dev_dat = nack; tick(2); end
            if (k == 11) dev_dat = 1'b1;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input int half, input int inject_at);
        int         s0, e0;
        logic [9:0] bits;
        s0 = n_sent;
        e0 = n_err;
        send_cmd(b);
        device(1'b0, half, 0, inject_at, bits);
        tick(10);
        check($sformatf("frame_%02h", b), bits, frame(b));
        check("sent_pulses", n_sent - s0, 1);
        check("err_pulses", n_err - e0, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        int         t, s0, e0;
        logic [9:0] bits;
        tick(3);
        check("reset_outs", {clk_dl, dat_dl, busy, sent, err}, 0);
        rst = 1'b0;
        tick(5);

        xfer(8'hF4, 30, 0);

        xfer(8'hFF, 25, 0);
        t = 0;
        while (busy && t < 20) begin tick(1); t++; end
        xfer(8'h00, 25, 0);

        repeat (6) xfer(8'($urandom), $urandom_range(10, 40), 0);

        xfer(8'hC3, 30, 3);
        tick(20);
        check("ignored_send", {clk_dl, busy}, 0);

        s0 = n_sent;
        e0 = n_err;
        send_cmd(8'hF4);
        device(1'b1, 30, 0, 0, bits);
        check("nack_frame", bits, frame(8'hF4));
`ifdef PS2_TX_RETRY_EN
        device(1'b0, 30, 0, 0, bits);
        tick(10);
        check("retry_frame", bits, frame(8'hF4));
        check("retry_sent", n_sent - s0, 1);
        check("retry_err", n_err - e0, 0);
`else
        tick(10);
        check("nack_sent", n_sent - s0, 0);
        check("nack_err", n_err - e0, 1);
`endif
        check("nack_busy", busy, 0);

        s0 = n_sent;
        e0 = n_err;
        send_cmd(8'hAA);
        device(1'b0, 25, 5, 0, bits);
        rst = 1'b1;
        tick(1);
        check("abort_lines", {clk_dl, dat_dl, busy}, 0);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        rst     = 1'b0;
        tick(10);
        check("abort_pulses", {16'(n_sent - s0), 16'(n_err - e0)}, 0);
        xfer(8'h55, 25, 0);

        s0 = n_sent;
        e0 = n_err;
        send_cmd(8'hF4);
        t = 0;
        while (!clk_dl && t < 50) begin tick(1); t++; end
        while (clk_dl && t < 4 * INH) begin tick(1); t++; end
        t = 0;
        while (!err && t < 3 * ST + INH) begin tick(1); t++; end
        check("timeout_lines", {clk_dl, dat_dl}, 0);
`ifdef PS2_TX_RETRY_EN
        check("timeout_at", t >= 2 * ST + INH && t <= 2 * ST + INH + 4, 1);
`else
        check("timeout_at", t >= ST && t <= ST + 4, 1);
`endif
        tick(5);
        check("timeout_err", n_err - e0, 1);
        check("timeout_sent", n_sent - s0, 0);
        check("timeout_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
